// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired CPU control unit: opcodes, ALU codes,
// enable/bus bit positions, FSM state encodings and instruction classes.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_INC = 5'b11111;

    localparam int EN_HI  = 16;
    localparam int EN_LO  = 17;
    localparam int EN_Z   = 18;
    localparam int EN_Y   = 19;
    localparam int EN_PC  = 20;
    localparam int EN_MDR = 21;
    localparam int EN_IR  = 24;
    localparam int EN_MAR = 25;
    localparam int EN_CON = 27;
    localparam int EN_OUT = 28;

    localparam int BS_HI  = 16;
    localparam int BS_LO  = 17;
    localparam int BS_ZHI = 18;
    localparam int BS_ZLO = 19;
    localparam int BS_PC  = 20;
    localparam int BS_MDR = 21;
    localparam int BS_IN  = 22;
    localparam int BS_C   = 23;

    // T4..T7 and the ld/st extra steps are folded into ST_EXEC plus a
    // 4-bit step index.
    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_T0    = 3'd1;
    localparam logic [2:0] ST_T1    = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_T2    = 3'd4;
    localparam logic [2:0] ST_T3    = 3'd5;
    localparam logic [2:0] ST_EXEC  = 3'd6;
    localparam logic [2:0] ST_HALT  = 3'd7;

    typedef enum logic [3:0] {
        IC_NONE,
        IC_RTYPE,
        IC_ITYPE,
        IC_LDI,
        IC_LD,
        IC_ST,
        IC_BR,
        IC_IN,
        IC_OUT,
        IC_MFHI,
        IC_MFLO,
        IC_HALT
    } instClass_t;

    function automatic instClass_t classify(input logic [4:0] op);
        instClass_t ic;
        case (op)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_SHR, OP_SHL:   ic = IC_RTYPE;
            OP_ADDI, OP_ANDI,
            OP_ORI:                  ic = IC_ITYPE;
            OP_LDI:                  ic = IC_LDI;
            OP_LD:                   ic = IC_LD;
            OP_ST:                   ic = IC_ST;
            OP_BR:                   ic = IC_BR;
            OP_IN:                   ic = IC_IN;
            OP_OUT:                  ic = IC_OUT;
            OP_MFHI:                 ic = IC_MFHI;
            OP_MFLO:                 ic = IC_MFLO;
            OP_HALT:                 ic = IC_HALT;
            default:                 ic = IC_NONE;
        endcase
        return ic;
    endfunction

    // Index of the final execute step; ld's memory wait does not advance
    // the step index, so it is not counted here.
    function automatic logic [3:0] lastStep(input instClass_t ic);
        logic [3:0] n;
        case (ic)
            IC_RTYPE, IC_ITYPE, IC_LDI: n = 4'd2;
            IC_LD, IC_ST:               n = 4'd4;
            IC_BR:                      n = 4'd3;
            default:                    n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired control unit: fetch (T0..T3 with optional RAM wait), decode and
// per-opcode execute steps driving all datapath control inputs.
// Ports: clk/clr (async active-high), IR opcode in [31:27], CONFF branch
// flag; enable/busSelect strobes, ALU op, register-field selects, RAM/MDR
// controls and run (low only in HALT).
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CONFF,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [4:0]  Control_Signals,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic        run
);

    localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);
    localparam logic [2:0] WAIT_LAST =
        (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;
    localparam bit NO_WAIT = (MEM_WAIT == 0);

    logic [2:0] state;
    logic [2:0] stateNext;
    logic [3:0] step;
    logic [3:0] stepNext;
    logic [2:0] waitCnt;
    logic       waitDone;
    logic       ldReadStep;
    logic [4:0] opcode;
    instClass_t iClass;
    logic       unusedIrBits;

    assign opcode       = IR[31:27];
    assign unusedIrBits = ^IR[26:0];
    assign iClass       = classify(opcode);
    assign waitDone     = (waitCnt == WAIT_MAX);
    // ld's read step holds for MEM_WAIT cycles before the MDR capture.
    assign ldReadStep   = (state == ST_EXEC) &&
                          (iClass == IC_LD) &&
                          (step == 4'd3);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_RESET;
            step    <= 4'd0;
            waitCnt <= 3'd0;
        end else begin
            state <= stateNext;
            step  <= stepNext;
            if ((state == ST_WAIT) ||
                (ldReadStep && !waitDone)) begin
                waitCnt <= waitCnt + 3'd1;
            end else begin
                waitCnt <= 3'd0;
            end
        end
    end

    always_comb begin
        stateNext = state;
        stepNext  = step;
        unique case (state)
            ST_RESET: stateNext = ST_T0;
            ST_T0:    stateNext = ST_T1;
            ST_T1:    stateNext = NO_WAIT ? ST_T2 : ST_WAIT;
            ST_WAIT: begin
                if (waitCnt == WAIT_LAST) begin
                    stateNext = ST_T2;
                end
            end
            ST_T2:    stateNext = ST_T3;
            // The fetched word must be on IR by T3 so that nop/halt
            // can leave without an execute cycle.
            ST_T3: begin
                stepNext = 4'd0;
                if (iClass == IC_HALT) begin
                    stateNext = ST_HALT;
                end else if (iClass == IC_NONE) begin
                    stateNext = ST_T0;
                end else begin
                    stateNext = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ldReadStep && !waitDone) begin
                    stepNext = step;
                end else if (step == lastStep(iClass)) begin
                    stateNext = ST_T0;
                    stepNext  = 4'd0;
                end else begin
                    stepNext = step + 4'd1;
                end
            end
            ST_HALT:  stateNext = ST_HALT;
            default:  stateNext = ST_RESET;
        endcase
    end

    always_comb begin
        enable          = '0;
        busSelect       = '0;
        Control_Signals = '0;
        Gra             = 1'b0;
        Grb             = 1'b0;
        Grc             = 1'b0;
        Rin             = 1'b0;
        Rout            = 1'b0;
        BAout           = 1'b0;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        WriteRAM        = 1'b0;
        run             = (state != ST_HALT);

        unique case (1'b1)
            (state == ST_T0): begin
                busSelect[BS_PC] = 1'b1;
                enable[EN_MAR]   = 1'b1;
                enable[EN_Z]     = 1'b1;
                Control_Signals  = ALU_INC;
            end
            (state == ST_T1): begin
                busSelect[BS_ZLO] = 1'b1;
                enable[EN_PC]     = 1'b1;
                ReadRAM           = 1'b1;
            end
            (state == ST_WAIT): begin
                ReadRAM = 1'b1;
            end
            (state == ST_T2): begin
                ReadRAM        = 1'b1;
                MD_Read        = 1'b1;
                enable[EN_MDR] = 1'b1;
            end
            (state == ST_T3): begin
                busSelect[BS_MDR] = 1'b1;
                enable[EN_IR]     = 1'b1;
            end
            (state == ST_EXEC): begin
                unique case (iClass)
                    IC_RTYPE, IC_ITYPE: begin
                        case (step)
                            4'd0: begin
                                Grb          = 1'b1;
                                Rout         = 1'b1;
                                enable[EN_Y] = 1'b1;
                            end
                            4'd1: begin
                                Control_Signals = opcode;
                                enable[EN_Z]    = 1'b1;
                                if (iClass == IC_RTYPE) begin
                                    Grc  = 1'b1;
                                    Rout = 1'b1;
                                end else begin
                                    busSelect[BS_C] = 1'b1;
                                end
                            end
                            4'd2: begin
                                busSelect[BS_ZLO] = 1'b1;
                                Gra               = 1'b1;
                                Rin               = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    IC_LDI, IC_LD, IC_ST: begin
                        case (step)
                            4'd0: begin
                                Grb          = 1'b1;
                                BAout        = 1'b1;
                                enable[EN_Y] = 1'b1;
                            end
                            4'd1: begin
                                busSelect[BS_C] = 1'b1;
                                Control_Signals = ALU_ADD;
                                enable[EN_Z]    = 1'b1;
                            end
                            4'd2: begin
                                busSelect[BS_ZLO] = 1'b1;
                                if (iClass == IC_LDI) begin
                                    Gra = 1'b1;
                                    Rin = 1'b1;
                                end else begin
                                    enable[EN_MAR] = 1'b1;
                                end
                            end
                            4'd3: begin
                                if (iClass == IC_LD) begin
                                    ReadRAM = 1'b1;
                                    if (waitDone) begin
                                        MD_Read        = 1'b1;
                                        enable[EN_MDR] = 1'b1;
                                    end
                                end else if (iClass == IC_ST) begin
                                    Gra            = 1'b1;
                                    Rout           = 1'b1;
                                    enable[EN_MDR] = 1'b1;
                                end
                            end
                            4'd4: begin
                                if (iClass == IC_LD) begin
                                    busSelect[BS_MDR] = 1'b1;
                                    Gra               = 1'b1;
                                    Rin               = 1'b1;
                                end else if (iClass == IC_ST) begin
                                    WriteRAM = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    IC_BR: begin
                        case (step)
                            4'd0: begin
                                Gra            = 1'b1;
                                Rout           = 1'b1;
                                enable[EN_CON] = 1'b1;
                            end
                            4'd1: begin
                                busSelect[BS_PC] = 1'b1;
                                enable[EN_Y]     = 1'b1;
                            end
                            4'd2: begin
                                busSelect[BS_C] = 1'b1;
                                Control_Signals = ALU_ADD;
                                enable[EN_Z]    = 1'b1;
                            end
                            4'd3: begin
                                if (CONFF) begin
                                    busSelect[BS_ZLO] = 1'b1;
                                    enable[EN_PC]     = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    IC_IN: begin
                        busSelect[BS_IN] = 1'b1;
                        Gra              = 1'b1;
                        Rin              = 1'b1;
                    end
                    IC_OUT: begin
                        Gra            = 1'b1;
                        Rout           = 1'b1;
                        enable[EN_OUT] = 1'b1;
                    end
                    IC_MFHI: begin
                        busSelect[BS_HI] = 1'b1;
                        Gra              = 1'b1;
                        Rin              = 1'b1;
                    end
                    IC_MFLO: begin
                        busSelect[BS_LO] = 1'b1;
                        Gra              = 1'b1;
                        Rin              = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        // Reset forces quiet outputs in the same cycle it is raised.
        if (clr) begin
            enable          = '0;
            busSelect       = '0;
            Control_Signals = '0;
            Gra             = 1'b0;
            Grb             = 1'b0;
            Grc             = 1'b0;
            Rin             = 1'b0;
            Rout            = 1'b0;
            BAout           = 1'b0;
            MD_Read         = 1'b0;
            ReadRAM         = 1'b0;
            WriteRAM        = 1'b0;
            run             = 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a cycle-level expectation list is
// built per instruction from the micro-step table, a monitor compares.
module tb_control_unit;

    localparam int MW = 3;

    localparam int E_Z   = 18;
    localparam int E_Y   = 19;
    localparam int E_PC  = 20;
    localparam int E_MDR = 21;
    localparam int E_IR  = 24;
    localparam int E_MAR = 25;
    localparam int E_CON = 27;
    localparam int E_OUT = 28;

    localparam int B_HI  = 16;
    localparam int B_LO  = 17;
    localparam int B_ZLO = 19;
    localparam int B_PC  = 20;
    localparam int B_MDR = 21;
    localparam int B_IN  = 22;
    localparam int B_C   = 23;

    localparam logic [4:0] A0   = 5'd0;
    localparam logic [4:0] AADD = 5'b00011;
    localparam logic [4:0] AINC = 5'b11111;

    // {Gra,Grb,Grc,Rin,Rout,BAout,MD_Read,ReadRAM,WriteRAM,run}
    localparam logic [9:0] NOF  = 10'd0;
    localparam logic [9:0] GRA  = 10'b1000000000;
    localparam logic [9:0] GRB  = 10'b0100000000;
    localparam logic [9:0] GRC  = 10'b0010000000;
    localparam logic [9:0] RIN  = 10'b0001000000;
    localparam logic [9:0] ROUT = 10'b0000100000;
    localparam logic [9:0] BAO  = 10'b0000010000;
    localparam logic [9:0] MDRD = 10'b0000001000;
    localparam logic [9:0] RD   = 10'b0000000100;
    localparam logic [9:0] WR   = 10'b0000000010;
    localparam logic [9:0] RUN  = 10'b0000000001;

    typedef struct packed {
        logic [31:0] en;
        logic [31:0] bs;
        logic [4:0]  alu;
        logic [9:0]  fl;
    } outs_t;

    typedef struct {
        outs_t v;
        string tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR;
    logic        CONFF;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [4:0]  Control_Signals;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        MD_Read, ReadRAM, WriteRAM, run;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    outs_t rv;

    control_unit #(.MEM_WAIT(MW)) dut (
        .clk(clk),
        .clr(clr),
        .IR(IR),
        .CONFF(CONFF),
        .enable(enable),
        .busSelect(busSelect),
        .Control_Signals(Control_Signals),
        .Gra(Gra),
        .Grb(Grb),
        .Grc(Grc),
        .Rin(Rin),
        .Rout(Rout),
        .BAout(BAout),
        .MD_Read(MD_Read),
        .ReadRAM(ReadRAM),
        .WriteRAM(WriteRAM),
        .run(run)
    );

    always #5 clk = ~clk;

    function automatic outs_t dutOuts();
        outs_t o;
        o.en  = enable;
        o.bs  = busSelect;
        o.alu = Control_Signals;
        o.fl  = {Gra, Grb, Grc, Rin, Rout, BAout,
                 MD_Read, ReadRAM, WriteRAM, run};
        return o;
    endfunction

    task automatic emit(input int bus, input int ea, input int eb,
                        input logic [4:0] alu, input logic [9:0] fl,
                        input string tag);
        exp_t e;
        e.v = '0;
        if (bus >= 0) e.v.bs[bus] = 1'b1;
        if (ea >= 0) e.v.en[ea] = 1'b1;
        if (eb >= 0) e.v.en[eb] = 1'b1;
        e.v.alu = alu;
        e.v.fl  = fl | RUN;
        e.tag   = $sformatf("%s.c%0d", tag, q.size());
        q.push_back(e);
    endtask

    task automatic model(input logic [4:0] op, input logic cf,
                         input string t);
        exp_t h;
        emit(B_PC, E_MAR, E_Z, AINC, NOF, t);
        emit(B_ZLO, E_PC, -1, A0, RD, t);
        repeat (MW) emit(-1, -1, -1, A0, RD, t);
        emit(-1, E_MDR, -1, A0, RD | MDRD, t);
        emit(B_MDR, E_IR, -1, A0, NOF, t);
        case (op)
            5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b00111, 5'b01000: begin
                emit(-1, E_Y, -1, A0, GRB | ROUT, t);
                emit(-1, E_Z, -1, op, GRC | ROUT, t);
                emit(B_ZLO, -1, -1, A0, GRA | RIN, t);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                emit(-1, E_Y, -1, A0, GRB | ROUT, t);
                emit(B_C, E_Z, -1, op, NOF, t);
                emit(B_ZLO, -1, -1, A0, GRA | RIN, t);
            end
            5'b00001, 5'b00000, 5'b00010: begin
                emit(-1, E_Y, -1, A0, GRB | BAO, t);
                emit(B_C, E_Z, -1, AADD, NOF, t);
                if (op == 5'b00001) begin
                    emit(B_ZLO, -1, -1, A0, GRA | RIN, t);
                end else if (op == 5'b00000) begin
                    emit(B_ZLO, E_MAR, -1, A0, NOF, t);
                    repeat (MW) emit(-1, -1, -1, A0, RD, t);
                    emit(-1, E_MDR, -1, A0, RD | MDRD, t);
                    emit(B_MDR, -1, -1, A0, GRA | RIN, t);
                end else begin
                    emit(B_ZLO, E_MAR, -1, A0, NOF, t);
                    emit(-1, E_MDR, -1, A0, GRA | ROUT, t);
                    emit(-1, -1, -1, A0, WR, t);
                end
            end
            5'b10010: begin
                emit(-1, E_CON, -1, A0, GRA | ROUT, t);
                emit(B_PC, E_Y, -1, A0, NOF, t);
                emit(B_C, E_Z, -1, AADD, NOF, t);
                if (cf) emit(B_ZLO, E_PC, -1, A0, NOF, t);
                else emit(-1, -1, -1, A0, NOF, t);
            end
            5'b10110: emit(B_IN, -1, -1, A0, GRA | RIN, t);
            5'b10111: emit(-1, E_OUT, -1, A0, GRA | ROUT, t);
            5'b11000: emit(B_HI, -1, -1, A0, GRA | RIN, t);
            5'b11001: emit(B_LO, -1, -1, A0, GRA | RIN, t);
            5'b11011: begin
                h.v = '0;
                for (int i = 0; i < 20; i++) begin
                    h.tag = $sformatf("%s.halt%0d", t, i);
                    q.push_back(h);
                end
            end
            default: ;
        endcase
    endtask

    task automatic runInstr(input logic [4:0] op, input logic cf);
        int n;
        model(op, cf, $sformatf("op%05b", op));
        n = q.size();
        IR = {op, 27'($urandom)};
        CONFF = cf;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkNow(input string name, input outs_t want);
        outs_t got;
        got = dutOuts();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic doReset(input string name);
        clr = 1'b1;
        #2;
        q.delete();
        checkNow({name, "_async"}, rv);
        @(posedge clk);
        #1;
        checkNow({name, "_held"}, rv);
        clr = 1'b0;
        emit(-1, -1, -1, A0, NOF, {name, "_rel"});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        outs_t got;
        if (!clr) begin
            checks++;
            if (!$onehot0(busSelect)) begin
                errors++;
                $display("FAIL busOneHot got %h want <=1 bit", busSelect);
            end
            checks++;
            if (ReadRAM && WriteRAM) begin
                errors++;
                $display("FAIL rdWrExcl got 1 want 0");
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                got = dutOuts();
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s got %h want %h", e.tag, got, e.v);
                end
            end
        end
    end

    initial begin
        logic [4:0] op;
        logic       cf;
        rv = '0;
        rv.fl = RUN;
        clr = 1'b1;
        IR = '0;
        CONFF = 1'b0;
        @(posedge clk);
        #1;
        doReset("por");

        runInstr(5'b00011, 1'b0);
        runInstr(5'b00000, 1'b1);
        runInstr(5'b10010, 1'b0);
        runInstr(5'b10010, 1'b1);
        runInstr(5'b00010, 1'b0);
        runInstr(5'b00001, 1'b0);
        runInstr(5'b01101, 1'b1);
        runInstr(5'b10110, 1'b0);
        runInstr(5'b10111, 1'b0);
        runInstr(5'b11000, 1'b0);
        runInstr(5'b11001, 1'b0);
        runInstr(5'b11010, 1'b0);
        runInstr(5'b01001, 1'b0);

        // Reset in the middle of an ld fetch wait.
        model(5'b00000, 1'b0, "ldrst");
        IR = {5'b00000, 27'($urandom)};
        repeat (3) @(posedge clk);
        #1;
        doReset("midld");
        runInstr(5'b00110, 1'b0);

        repeat (150) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            cf = 1'($urandom_range(0, 1));
            runInstr(op, cf);
        end

        runInstr(5'b11011, 1'b0);
        doReset("halt");
        runInstr(5'b00100, 1'b0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
